// File: rtl/mat_mul_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mat_mul_seq_if : start, ROM address/data and C result port bundle |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface mat_mul_seq_if #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int ACC_W = 2*DW+2
);
  logic             start;
  logic [AW-1:0]    a_addr;
  logic [DW-1:0]    a_data;
  logic [AW-1:0]    b_addr;
  logic [DW-1:0]    b_data;
  logic             c_valid;
  logic             out_ready;
  logic [ACC_W-1:0] c_data;
  logic [1:0]       c_row;
  logic [1:0]       c_col;
  logic             busy;
  logic             done;

  modport master (
    input  start, a_data, b_data, out_ready,
    output a_addr, b_addr, c_valid, c_data, c_row, c_col, busy, done
  );

  modport slave (
    output start, a_data, b_data, out_ready,
    input  a_addr, b_addr, c_valid, c_data, c_row, c_col, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/mat_mul_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mat_mul_seq : sequential C = A x B over column-major coefficient  |
// | ROMs, one MAC per cycle, row-major valid/ready result stream      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mat_mul_seq #(
  parameter int N     = 3,
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int ACC_W = 2*DW+2
) (
  input  wire logic      clk,
  input  wire logic      rst,
  mat_mul_seq_if.master  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_LAST  = 3'd2,
    S_HOLD  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [1:0] C_NM1 = 2'(N-1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_i;
  logic [1:0]       r_j;
  logic [1:0]       r_k;
  logic             r_load;
  logic [ACC_W-1:0] r_acc;
  logic             w_xfer;
  logic             w_last_el;
  logic             w_mac;
  logic [2*DW-1:0]  w_prod;
  logic [ACC_W-1:0] w_prod_ext;

  assign w_prod     = {{DW{1'b0}}, io_bus.a_data} * {{DW{1'b0}}, io_bus.b_data};
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_last_el  = (r_i == C_NM1) && (r_j == C_NM1);
  // ROM data lags the address by one cycle: every ISSUE cycle after k=0, plus LAST, carries a product
  assign w_mac      = ((r_state == S_ISSUE) && (r_k != 2'd0)) || (r_state == S_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_xfer         = 1'b0;
    io_bus.a_addr  = '0;
    io_bus.b_addr  = '0;
    io_bus.c_valid = 1'b0;
    io_bus.c_data  = '0;
    io_bus.c_row   = '0;
    io_bus.c_col   = '0;
    io_bus.busy    = 1'b1;
    io_bus.done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        io_bus.busy = 1'b0;
        if (io_bus.start) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        io_bus.a_addr = AW'(r_k) * AW'(N) + AW'(r_i);
        io_bus.b_addr = AW'(r_j) * AW'(N) + AW'(r_k);
        if (r_k == C_NM1) w_next = S_LAST;
      end
      S_LAST: begin
        w_next = S_HOLD;
      end
      S_HOLD: begin
        io_bus.c_valid = 1'b1;
        io_bus.c_data  = r_acc;
        io_bus.c_row   = r_i;
        io_bus.c_col   = r_j;
        w_xfer         = io_bus.out_ready;
        if (io_bus.out_ready) w_next = w_last_el ? S_FIN : S_ISSUE;
      end
      S_FIN: begin
        io_bus.done = 1'b1;
        w_next      = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_load <= 1'b0;
      r_acc  <= '0;
    end else begin
      r_load <= (r_state == S_ISSUE) && (r_k == 2'd0);
      if (r_state == S_ISSUE) begin
        r_k <= (r_k == C_NM1) ? 2'd0 : r_k + 2'd1;
      end
      if (w_mac) begin
        r_acc <= r_load ? w_prod_ext : r_acc + w_prod_ext;
      end
      if (w_xfer) begin
        if (r_j == C_NM1) begin
          r_j <= '0;
          r_i <= (r_i == C_NM1) ? 2'd0 : r_i + 2'd1;
        end else begin
          r_j <= r_j + 2'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mat_mul_seq.sv
`default_nettype none
// Bench for mat_mul_seq: ROM models, matrix-level reference model, directed and random jobs.
module tb_mat_mul_seq;
  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int ACC_W = 2*DW+2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mat_mul_seq_if #(.DW(DW), .AW(AW), .ACC_W(ACC_W)) bus ();

  mat_mul_seq #(.N(N), .DW(DW), .AW(AW), .ACC_W(ACC_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  logic [DW-1:0] rom_a [2**AW];
  logic [DW-1:0] rom_b [2**AW];

  always_ff @(posedge clk) begin
    bus.a_data <= rom_a[bus.a_addr];
    bus.b_data <= rom_b[bus.b_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: unpack column-major ROMs into matrices, then textbook row-by-column product
  function automatic logic [ACC_W-1:0] ref_c(input int i, input int j);
    int unsigned ma [N][N];
    int unsigned mb [N][N];
    int unsigned s;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = rom_a[c*N+r];
        mb[r][c] = rom_b[c*N+r];
      end
    s = 0;
    for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
    return ACC_W'(s);
  endfunction

  task automatic clear_roms();
    for (int a = 0; a < 2**AW; a++) begin
      rom_a[a] = '0;
      rom_b[a] = '0;
    end
  endtask

  task automatic load_directed();
    logic [DW-1:0] av [9];
    av = '{8'hE3, 8'hC0, 8'h76, 8'hDA, 8'h70, 8'hC8, 8'h20, 8'h20, 8'h4B};
    clear_roms();
    for (int a = 0; a < N*N; a++) rom_a[a] = av[a];
    for (int c = 0; c < N; c++) rom_b[c*N+c] = 8'd1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(bus.c_valid), 64'd0);
    chk({tag, "_data"},  64'(bus.c_data),  64'd0);
    chk({tag, "_rowcol"}, 64'({bus.c_row, bus.c_col}), 64'd0);
    chk({tag, "_busydone"}, 64'({bus.busy, bus.done}), 64'd0);
    chk({tag, "_addr"}, 64'({bus.a_addr, bus.b_addr}), 64'd0);
  endtask

  int xfers, dones, first_valid, done_cyc;
  logic [ACC_W-1:0] got [N*N];

  task automatic run_job(input int stall_el, input int stall_len, input bit rnd_rdy,
                         input int restart_el, input int rst_el);
    int cyc, el, stall, bad;
    bit done_seen;
    xfers = 0; dones = 0; first_valid = -1; done_cyc = -1;
    el = 0; stall = 0; done_seen = 1'b0;
    for (int e = 0; e < N*N; e++) got[e] = '0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    chk("busy_rise", 64'(bus.busy), 64'd1);
    while (cyc < 600) begin
      if (done_seen) begin
        chk("busy_fall", 64'(bus.busy), 64'd0);
        break;
      end
      if (el == rst_el && bus.busy && !bus.c_valid) begin
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk_idle("rst_mid");
        bad = 0;
        repeat (6) begin
          @(posedge clk); #1;
          if (bus.c_valid || bus.done || bus.busy) bad++;
        end
        chk("rst_abort", 64'(bad), 64'd0);
        return;
      end
      if (el == stall_el && bus.c_valid && stall < stall_len) begin
        bus.out_ready = 1'b0;
        stall++;
        chk("stall_valid", 64'(bus.c_valid), 64'd1);
        chk("stall_data", 64'(bus.c_data), 64'(ref_c(el / N, el % N)));
        chk("stall_rowcol", 64'({bus.c_row, bus.c_col}), 64'({2'(el / N), 2'(el % N)}));
        chk("stall_addr", 64'({bus.a_addr, bus.b_addr}), 64'd0);
      end else begin
        bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      bus.start = (el == restart_el);
      if (bus.done) begin
        dones++;
        done_cyc = cyc;
        done_seen = 1'b1;
      end
      if (bus.c_valid && first_valid < 0) first_valid = cyc;
      if (bus.c_valid && bus.out_ready) begin
        if (el < N*N) begin
          got[el] = bus.c_data;
          chk("c_data", 64'(bus.c_data), 64'(ref_c(el / N, el % N)));
          chk("c_rowcol", 64'({bus.c_row, bus.c_col}), 64'({2'(el / N), 2'(el % N)}));
        end
        el++;
        xfers++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    chk("xfer_count", 64'(xfers), 64'(N*N));
    chk("done_count", 64'(dones), 64'd1);
  endtask

  initial begin
    int exp1 [9];
    exp1 = '{227, 218, 32, 192, 112, 32, 118, 200, 75};
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    clear_roms();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Identity B: C reproduces A row-major; ready tied high for latency
    load_directed();
    run_job(-1, 0, 1'b0, -1, -1);
    for (int e = 0; e < N*N; e++) chk("t1_seq", 64'(got[e]), 64'(exp1[e]));
    chk("first_valid_cyc", 64'(first_valid), 64'd5);
    chk("done_cyc", 64'(done_cyc), 64'd46);

    // Saturated operands: widest sum
    for (int a = 0; a < N*N; a++) begin
      rom_a[a] = 8'hFF;
      rom_b[a] = 8'hFF;
    end
    run_job(-1, 0, 1'b0, -1, -1);
    for (int e = 0; e < N*N; e++) chk("t2_max", 64'(got[e]), 64'd195075);

    // Back-pressure on element (1,1)
    load_directed();
    run_job(4, 7, 1'b0, -1, -1);
    chk("t4_el11", 64'(got[4]), 64'd112);
    chk("t4_last", 64'(got[8]), 64'd75);

    // start while busy is ignored
    run_job(-1, 0, 1'b0, 4, -1);

    // Reset during element (0,2), then a clean run
    run_job(-1, 0, 1'b0, -1, 2);
    run_job(-1, 0, 1'b0, -1, -1);
    for (int e = 0; e < N*N; e++) chk("t6_seq", 64'(got[e]), 64'(exp1[e]));

    // Random coefficients with random consumer readiness
    repeat (4) begin
      for (int a = 0; a < N*N; a++) begin
        rom_a[a] = DW'($urandom);
        rom_b[a] = DW'($urandom);
      end
      run_job(-1, 0, 1'b1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
